vc8_dac_scanner: RTL and testbench

VC8_DAC_SCANNER -- requirements
Module: vc8_dac_scanner

---
 rtl/vc8_pkg.sv | 30 +++
 rtl/vc8_dwell_timer.sv | 26 ++
 rtl/vc8_dac_scanner.sv | 214 +++++++++++++++++++++
 tb/tb_vc8_dac_scanner.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc8_pkg.sv
// Shared VC-8 definitions: scanner state encoding, ID word, RAM word layout
// and the video RAM read latency.
package vc8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_MOVE = 3'd2,
    ST_PLOT = 3'd3,
    ST_NEXT = 3'd4
  } vc8_state_e;

  localparam logic [31:0] VC8_ID  = 32'h5644_0001;
  localparam logic [31:0] BAD_IDX = 32'hDEAD_BEEF;

  // Point word in video RAM: {intens[21:20], y[19:10], x[9:0]}
  localparam int X_LSB = 0;
  localparam int X_MSB = 9;
  localparam int Y_LSB = 10;
  localparam int Y_MSB = 19;
  localparam int I_LSB = 20;
  localparam int I_MSB = 21;

  // Cycles from ramenab rising to ramdata being valid
  localparam int RAM_LAT = 3;

  // Mid-scale DAC code used while parked
  localparam logic [9:0] DAC_MID = 10'o1000;

endpackage

// File: rtl/vc8_dwell_timer.sv
// Loadable 10-bit down-counter; done is high on the last cycle of a dwell.
// A load of N gives a dwell of N cycles (0 and 1 both give one cycle).
module vc8_dwell_timer (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       load_i,
  input  logic [9:0] val_i,
  output logic       done_o
);

  logic [9:0] cnt_q;

  // Count down from the loaded value, parking at zero
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt_q <= 10'd0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != 10'd0) begin
      cnt_q <= cnt_q - 10'd1;
    end
  end

  assign done_o = (cnt_q[9:1] == 9'd0);

endmodule

// File: rtl/vc8_dac_scanner.sv
// VC-8 DAC scanner: pulls points out of the video RAM ring, drives the
// deflection DACs, waits for the beam to settle, then unblanks for a dwell
// scaled by the point intensity. Configuration and ring pointers are visible
// through a small ARM register window.
module vc8_dac_scanner
  import vc8_pkg::*;
#(
  parameter logic [7:0] SETTLE_DFLT = 8'd40,
  parameter logic [7:0] PULSE_DFLT  = 8'd25
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [14:0] insert,
  output logic [14:0] ramaddr,
  output logic        ramenab,
  input  logic [21:0] ramdata,
  output logic [14:0] remove,
  output logic [9:0]  dacx,
  output logic [9:0]  dacy,
  output logic        dacstb,
  output logic        zunblank,
  output logic [1:0]  zintens
);

  // A zero dwell still lasts one cycle
  function automatic logic [7:0] at_least_one(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  // Unblank dwell: base pulse doubled per intensity step, kept to 10 bits
  function automatic logic [9:0] plot_len(input logic [7:0] p, input logic [1:0] i);
    logic [9:0] base;
    base = {2'b00, at_least_one(p)};
    return base << i;
  endfunction

  vc8_state_e  state_q;
  logic        enable_q, enable_d;
  logic [7:0]  settle_q, settle_d;
  logic [7:0]  pulse_q, pulse_d;
  logic [14:0] remove_q, remove_d;
  logic [15:0] points_q, points_d;
  logic        flushed_q, flushed_d;
  logic [1:0]  rd_cnt_q;
  logic [14:0] ramaddr_q;
  logic        ramenab_q;
  logic [9:0]  dacx_q, dacy_q;
  logic [1:0]  zintens_q;
  logic        dacstb_q;
  logic        zunblank_q;

  logic        wr_cfg, wr_flush, capture;
  logic        tmr_load, tmr_done;
  logic [9:0]  tmr_val;
  logic        unused_wdata;

  assign unused_wdata = ^armwdata[30:16];

  // Decode ARM writes and compute next values of the register-window state
  always_comb begin
    wr_cfg    = armwrite && (armwaddr == 2'd1);
    wr_flush  = armwrite && (armwaddr == 2'd2) && armwdata[31];
    capture   = (state_q == ST_READ) && (rd_cnt_q == 2'(RAM_LAT - 1));

    enable_d  = enable_q;
    settle_d  = settle_q;
    pulse_d   = pulse_q;
    if (wr_cfg) begin
      enable_d = armwdata[31];
      settle_d = armwdata[15:8];
      pulse_d  = armwdata[7:0];
    end

    // A flush during a point keeps the pointer at the flushed value, so the
    // in-flight point neither advances it nor counts as plotted.
    remove_d = remove_q;
    if (capture && !flushed_q) remove_d = remove_q + 15'd1;
    if (wr_flush) remove_d = insert;

    points_d = points_q;
    if ((state_q == ST_NEXT) && !flushed_q) points_d = points_q + 16'd1;
    if (wr_flush) points_d = 16'd0;

    flushed_d = flushed_q;
    if (state_q == ST_IDLE) flushed_d = 1'b0;
    if (wr_flush && (state_q != ST_IDLE)) flushed_d = 1'b1;
  end

  // Register window state
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      enable_q  <= 1'b0;
      settle_q  <= SETTLE_DFLT;
      pulse_q   <= PULSE_DFLT;
      remove_q  <= 15'd0;
      points_q  <= 16'd0;
      flushed_q <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      settle_q  <= settle_d;
      pulse_q   <= pulse_d;
      remove_q  <= remove_d;
      points_q  <= points_d;
      flushed_q <= flushed_d;
    end
  end

  // Dwell timer is loaded with the settle time on capture and with the
  // unblank time when settling completes
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = {2'b00, at_least_one(settle_q)};
    if (capture) begin
      tmr_load = 1'b1;
    end else if ((state_q == ST_MOVE) && tmr_done) begin
      tmr_load = 1'b1;
      tmr_val  = plot_len(pulse_q, zintens_q);
    end
  end

  vc8_dwell_timer u_dwell (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  // Point sequencer with registered RAM and beam outputs
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= 2'd0;
      ramaddr_q  <= 15'd0;
      ramenab_q  <= 1'b0;
      dacx_q     <= DAC_MID;
      dacy_q     <= DAC_MID;
      zintens_q  <= 2'd0;
      dacstb_q   <= 1'b0;
      zunblank_q <= 1'b0;
    end else begin
      dacstb_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          zunblank_q <= 1'b0;
          if (enable_q && (remove_q != insert) && !wr_flush) begin
            state_q   <= ST_READ;
            ramaddr_q <= remove_q;
            ramenab_q <= 1'b1;
            rd_cnt_q  <= 2'd0;
          end
        end
        ST_READ: begin
          if (capture) begin
            ramenab_q <= 1'b0;
            dacx_q    <= ramdata[X_MSB:X_LSB];
            dacy_q    <= ramdata[Y_MSB:Y_LSB];
            zintens_q <= ramdata[I_MSB:I_LSB];
            dacstb_q  <= 1'b1;
            state_q   <= ST_MOVE;
          end else begin
            rd_cnt_q <= rd_cnt_q + 2'd1;
          end
        end
        ST_MOVE: begin
          if (tmr_done) begin
            zunblank_q <= 1'b1;
            state_q    <= ST_PLOT;
          end
        end
        ST_PLOT: begin
          if (tmr_done) begin
            zunblank_q <= 1'b0;
            state_q    <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          zunblank_q <= 1'b0;
          ramenab_q  <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  // ARM read mux
  always_comb begin
    case (armraddr)
      2'd0:    armrdata = VC8_ID;
      2'd1:    armrdata = {enable_q, 15'b0, settle_q, pulse_q};
      2'd2:    armrdata = {1'b0, remove_q, 1'b0, insert};
      2'd3:    armrdata = {16'b0, points_q};
      default: armrdata = BAD_IDX;
    endcase
  end

  assign ramaddr  = ramaddr_q;
  assign ramenab  = ramenab_q;
  assign remove   = remove_q;
  assign dacx     = dacx_q;
  assign dacy     = dacy_q;
  assign dacstb   = dacstb_q;
  assign zunblank = zunblank_q;
  assign zintens  = zintens_q;

endmodule

// File: tb/tb_vc8_dac_scanner.sv
// Bench for the VC-8 DAC scanner: a modelled video RAM with 3-cycle read
// latency, a passive monitor logging reads, DAC strobes and unblank runs,
// and per-scenario tasks comparing against expectations from point rules.
module tb_vc8_dac_scanner;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        armwrite = 1'b0;
  logic [1:0]  armraddr = 2'd0;
  logic [1:0]  armwaddr = 2'd0;
  logic [31:0] armwdata = 32'd0;
  logic [31:0] armrdata;
  logic [14:0] insert = 15'd0;
  logic [14:0] ramaddr;
  logic        ramenab;
  logic [21:0] ramdata;
  logic [14:0] remove;
  logic [9:0]  dacx, dacy;
  logic        dacstb, zunblank;
  logic [1:0]  zintens;

  int n_cmp = 0;
  int n_bad = 0;

  logic [21:0] mem [0:32767];

  int          cyc = 0;
  int          en_run = 0;
  int          hi_run = 0;
  int          bad_blank = 0;
  logic [14:0] en_addr = 15'd0;
  logic [14:0] q_en_addr [$];
  int          q_en_len [$];
  logic [21:0] q_stb [$];
  int          q_stb_cyc [$];
  int          q_hi [$];

  vc8_dac_scanner dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .armwrite (armwrite),
    .armraddr (armraddr),
    .armwaddr (armwaddr),
    .armwdata (armwdata),
    .armrdata (armrdata),
    .insert   (insert),
    .ramaddr  (ramaddr),
    .ramenab  (ramenab),
    .ramdata  (ramdata),
    .remove   (remove),
    .dacx     (dacx),
    .dacy     (dacy),
    .dacstb   (dacstb),
    .zunblank (zunblank),
    .zintens  (zintens)
  );

  always #5 CLOCK = ~CLOCK;

  // RAM data only becomes valid once ramenab has been high for 3 cycles
  assign ramdata = (ramenab && en_run >= 3) ? mem[ramaddr] : 22'h2AAAAA;

  initial begin
    forever begin
      @(negedge CLOCK);
      cyc++;
      if (ramenab) begin
        en_run++;
        en_addr = ramaddr;
      end else if (en_run != 0) begin
        q_en_addr.push_back(en_addr);
        q_en_len.push_back(en_run);
        en_run = 0;
      end
      if (dacstb) begin
        q_stb.push_back({zintens, dacy, dacx});
        q_stb_cyc.push_back(cyc);
      end
      if (zunblank) hi_run++;
      else if (hi_run != 0) begin
        q_hi.push_back(hi_run);
        hi_run = 0;
      end
      if (zunblank && (ramenab || dacstb)) bad_blank++;
    end
  end

  // Reference rules for one point
  function automatic int exp_hi(input int p, input int i);
    return ((p == 0) ? 1 : p) << i;
  endfunction

  // idle + read latency + settle + unblank + next
  function automatic int exp_period(input int s, input int p, input int i);
    return 1 + 3 + ((s == 0) ? 1 : s) + exp_hi(p, i) + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    armwrite = 1'b0;
    tick(2);
    RESET = 1'b0;
    tick(1);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    armwaddr = idx;
    armwdata = d;
    armwrite = 1'b1;
    tick(1);
    armwrite = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] v);
    armraddr = idx;
    #1;
    v = armrdata;
  endtask

  task automatic wait_hi(input int target, input int bound, output bit ok);
    int k;
    k = 0;
    while (q_hi.size() < target && k < bound) begin
      tick(1);
      k++;
    end
    ok = (q_hi.size() >= target);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    insert = 15'd0;
    do_reset();
    rd(2'd0, v);
    n_cmp++; if (v !== 32'h5644_0001) begin n_bad++; $display("FAIL reset_id: got %h want 56440001", v); end
    rd(2'd1, v);
    n_cmp++; if (v !== {1'b0, 15'b0, 8'd40, 8'd25}) begin n_bad++; $display("FAIL reset_cfg: got %h want %h", v, {1'b0, 15'b0, 8'd40, 8'd25}); end
    rd(2'd2, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL reset_ptrs: got %h want 0", v); end
    rd(2'd3, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL reset_points: got %h want 0", v); end
    n_cmp++; if (dacx !== 10'h200 || dacy !== 10'h200) begin n_bad++; $display("FAIL reset_dac: got %h/%h want 200/200", dacx, dacy); end
    n_cmp++; if ({zintens, dacstb, zunblank, ramenab} !== 5'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 00000", {zintens, dacstb, zunblank, ramenab}); end
    n_cmp++; if (ramaddr !== 15'd0 || remove !== 15'd0) begin n_bad++; $display("FAIL reset_addr: got %h/%h want 0/0", ramaddr, remove); end
  endtask

  task automatic test_first_point();
    logic [31:0] v;
    bit ok;
    int b_hi, b_en, b_stb, got;
    do_reset();
    b_hi = q_hi.size(); b_en = q_en_len.size(); b_stb = q_stb.size();
    mem[0] = 22'h2_80200;
    insert = 15'd1;
    wr(2'd1, {1'b1, 15'b0, 8'd40, 8'd25});
    wait_hi(b_hi + 1, 600, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL first_timeout: got %0d runs want 1", q_hi.size() - b_hi); end
    tick(20);
    got = (q_en_len.size() > b_en) ? q_en_len[b_en] : -1;
    n_cmp++; if (got != 3) begin n_bad++; $display("FAIL first_ramenab_len: got %0d want 3", got); end
    got = (q_en_addr.size() > b_en) ? int'(q_en_addr[b_en]) : -1;
    n_cmp++; if (got != 0) begin n_bad++; $display("FAIL first_ramaddr: got %0d want 0", got); end
    got = (q_stb.size() > b_stb) ? int'(q_stb[b_stb]) : -1;
    n_cmp++; if (got != 32'h28_0200) begin n_bad++; $display("FAIL first_dac: got %h want 280200", got); end
    got = (q_hi.size() > b_hi) ? q_hi[b_hi] : -1;
    n_cmp++; if (got != 100) begin n_bad++; $display("FAIL first_unblank: got %0d want 100", got); end
    n_cmp++; if (remove !== 15'd1) begin n_bad++; $display("FAIL first_remove: got %h want 1", remove); end
    rd(2'd3, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL first_points: got %h want 1", v); end
    rd(2'd2, v);
    n_cmp++; if (v !== {1'b0, 15'd1, 1'b0, 15'd1}) begin n_bad++; $display("FAIL first_ptrs: got %h want 00010001", v); end
    n_cmp++; if (q_en_len.size() - b_en != 1) begin n_bad++; $display("FAIL first_idle: got %0d reads want 1", q_en_len.size() - b_en); end
  endtask

  task automatic test_points(input int np, input int s, input int p, input bit zero_int);
    logic [21:0] w [8];
    logic [31:0] v;
    bit ok;
    int b_hi, b_en, b_stb, bb0, got, ex;
    do_reset();
    b_hi = q_hi.size(); b_en = q_en_len.size(); b_stb = q_stb.size(); bb0 = bad_blank;
    for (int k = 0; k < np; k++) begin
      w[k] = 22'($urandom());
      if (zero_int) w[k][21:20] = 2'b00;
      mem[k] = w[k];
    end
    insert = 15'(np);
    wr(2'd1, {1'b1, 15'b0, 8'(s), 8'(p)});
    wait_hi(b_hi + np, 4000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pts_timeout: got %0d runs want %0d", q_hi.size() - b_hi, np); end
    tick(20);
    for (int k = 0; k < np; k++) begin
      got = (q_stb.size() > b_stb + k) ? int'(q_stb[b_stb + k]) : -1;
      n_cmp++; if (got != int'(w[k])) begin n_bad++; $display("FAIL pts_dac[%0d]: got %h want %h", k, got, w[k]); end
      got = (q_hi.size() > b_hi + k) ? q_hi[b_hi + k] : -1;
      ex = exp_hi(p, int'(w[k][21:20]));
      n_cmp++; if (got != ex) begin n_bad++; $display("FAIL pts_unblank[%0d]: got %0d want %0d", k, got, ex); end
      got = (q_en_addr.size() > b_en + k) ? int'(q_en_addr[b_en + k]) : -1;
      n_cmp++; if (got != k) begin n_bad++; $display("FAIL pts_ramaddr[%0d]: got %0d want %0d", k, got, k); end
      if (k > 0) begin
        got = (q_stb_cyc.size() > b_stb + k) ? q_stb_cyc[b_stb + k] - q_stb_cyc[b_stb + k - 1] : -1;
        ex = exp_period(s, p, int'(w[k-1][21:20]));
        n_cmp++; if (got != ex) begin n_bad++; $display("FAIL pts_period[%0d]: got %0d want %0d", k, got, ex); end
      end
    end
    n_cmp++; if (remove !== 15'(np)) begin n_bad++; $display("FAIL pts_remove: got %0d want %0d", remove, np); end
    rd(2'd3, v);
    n_cmp++; if (v !== 32'(np)) begin n_bad++; $display("FAIL pts_points: got %0d want %0d", v, np); end
    n_cmp++; if (bad_blank != bb0) begin n_bad++; $display("FAIL pts_blank_overlap: got %0d want 0", bad_blank - bb0); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    logic [21:0] w;
    bit ok;
    int b_hi, b_en, b_stb, got;
    do_reset();
    b_hi = q_hi.size(); b_en = q_en_len.size(); b_stb = q_stb.size();
    insert = 15'h7FFF;
    wr(2'd2, 32'h8000_0000);
    n_cmp++; if (remove !== 15'h7FFF) begin n_bad++; $display("FAIL wrap_flush: got %h want 7fff", remove); end
    w = 22'($urandom());
    mem[15'h7FFF] = w;
    insert = 15'd0;
    wr(2'd1, {1'b1, 15'b0, 8'd2, 8'd3});
    wait_hi(b_hi + 1, 600, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_timeout: got %0d runs want 1", q_hi.size() - b_hi); end
    tick(30);
    got = (q_en_addr.size() > b_en) ? int'(q_en_addr[b_en]) : -1;
    n_cmp++; if (got != 32'h7FFF) begin n_bad++; $display("FAIL wrap_ramaddr: got %h want 7fff", got); end
    got = (q_stb.size() > b_stb) ? int'(q_stb[b_stb]) : -1;
    n_cmp++; if (got != int'(w)) begin n_bad++; $display("FAIL wrap_dac: got %h want %h", got, w); end
    n_cmp++; if (remove !== 15'd0) begin n_bad++; $display("FAIL wrap_remove: got %h want 0", remove); end
    rd(2'd3, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL wrap_points: got %0d want 1", v); end
    n_cmp++; if (q_en_len.size() - b_en != 1) begin n_bad++; $display("FAIL wrap_idle: got %0d reads want 1", q_en_len.size() - b_en); end
  endtask

  task automatic test_flush_mid();
    logic [31:0] v;
    bit ok;
    int b_hi, b_en, k, got;
    do_reset();
    b_hi = q_hi.size(); b_en = q_en_len.size();
    mem[0] = 22'h1_12345;
    insert = 15'd1;
    wr(2'd1, {1'b1, 15'b0, 8'd4, 8'd20});
    k = 0;
    while (zunblank !== 1'b1 && k < 200) begin tick(1); k++; end
    n_cmp++; if (zunblank !== 1'b1) begin n_bad++; $display("FAIL flush_no_plot: got %b want 1", zunblank); end
    tick(5);
    insert = 15'h0010;
    wr(2'd2, 32'h8000_0000);
    wait_hi(b_hi + 1, 200, ok);
    tick(30);
    got = (q_hi.size() > b_hi) ? q_hi[b_hi] : -1;
    n_cmp++; if (got != 40) begin n_bad++; $display("FAIL flush_unblank: got %0d want 40", got); end
    n_cmp++; if (remove !== 15'h0010) begin n_bad++; $display("FAIL flush_remove: got %h want 0010", remove); end
    rd(2'd3, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL flush_points: got %0d want 0", v); end
    n_cmp++; if (q_en_len.size() - b_en != 1 || ramenab !== 1'b0) begin n_bad++; $display("FAIL flush_idle: got %0d reads want 1", q_en_len.size() - b_en); end
  endtask

  task automatic test_enable_clear();
    logic [31:0] v;
    bit ok;
    int b_hi, b_en, b_stb, k, got, ex;
    do_reset();
    b_hi = q_hi.size(); b_en = q_en_len.size(); b_stb = q_stb.size();
    for (int j = 0; j < 3; j++) mem[j] = 22'($urandom());
    insert = 15'd3;
    wr(2'd1, {1'b1, 15'b0, 8'd3, 8'd5});
    k = 0;
    while (q_stb.size() == b_stb && k < 100) begin tick(1); k++; end
    wr(2'd1, {1'b0, 15'b0, 8'd3, 8'd5});
    wait_hi(b_hi + 1, 200, ok);
    tick(40);
    ex = exp_hi(5, int'(mem[0][21:20]));
    got = (q_hi.size() > b_hi) ? q_hi[b_hi] : -1;
    n_cmp++; if (got != ex) begin n_bad++; $display("FAIL encl_unblank: got %0d want %0d", got, ex); end
    n_cmp++; if (q_hi.size() - b_hi != 1) begin n_bad++; $display("FAIL encl_count: got %0d points want 1", q_hi.size() - b_hi); end
    n_cmp++; if (remove !== 15'd1) begin n_bad++; $display("FAIL encl_remove: got %h want 1", remove); end
    rd(2'd3, v);
    n_cmp++; if (v !== 32'd1) begin n_bad++; $display("FAIL encl_points: got %0d want 1", v); end
  endtask

  task automatic test_reset_mid_plot();
    logic [31:0] v;
    int k;
    do_reset();
    mem[0] = 22'h3_0F0F0;
    insert = 15'd1;
    wr(2'd1, {1'b1, 15'b0, 8'd2, 8'd10});
    k = 0;
    while (zunblank !== 1'b1 && k < 200) begin tick(1); k++; end
    n_cmp++; if (zunblank !== 1'b1) begin n_bad++; $display("FAIL rstplot_no_plot: got %b want 1", zunblank); end
    tick(10);
    RESET = 1'b1;
    armwaddr = 2'd1;
    armwdata = 32'h8000_FFFF;
    armwrite = 1'b1;
    @(posedge CLOCK);
    #1;
    n_cmp++; if (zunblank !== 1'b0) begin n_bad++; $display("FAIL rstplot_unblank: got %b want 0", zunblank); end
    n_cmp++; if (dacx !== 10'h200 || dacy !== 10'h200 || zintens !== 2'd0) begin n_bad++; $display("FAIL rstplot_dac: got %h/%h/%0d want 200/200/0", dacx, dacy, zintens); end
    n_cmp++; if ({dacstb, ramenab} !== 2'b00 || ramaddr !== 15'd0 || remove !== 15'd0) begin n_bad++; $display("FAIL rstplot_ctl: got %b %h %h want 00 0 0", {dacstb, ramenab}, ramaddr, remove); end
    @(negedge CLOCK);
    RESET = 1'b0;
    armwrite = 1'b0;
    rd(2'd1, v);
    n_cmp++; if (v !== {1'b0, 15'b0, 8'd40, 8'd25}) begin n_bad++; $display("FAIL rstplot_cfg: got %h want %h", v, {1'b0, 15'b0, 8'd40, 8'd25}); end
    tick(20);
    rd(2'd3, v);
    n_cmp++; if (v !== 32'd0 || ramenab !== 1'b0) begin n_bad++; $display("FAIL rstplot_idle: got points %0d ramenab %b want 0 0", v, ramenab); end
  endtask

  initial begin
    test_reset();
    test_first_point();
    test_points(6, $urandom_range(0, 20), $urandom_range(0, 15), 1'b0);
    test_points(5, $urandom_range(0, 20), $urandom_range(0, 15), 1'b0);
    test_points(3, 0, 0, 1'b1);
    test_wrap();
    test_flush_mid();
    test_enable_clear();
    test_reset_mid_plot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
